fifo_1rw_large_host: RTL and testbench

- Initiator-side controller for the single-port large FIFO command interface (one shared v / enq_not_deq command per cycle, full/empty status, synchronous read data).
- Converts an independent valid/ready enqueue stream and a valid/yumi dequeue stream into that one-command-per-cycle protocol.
- Arbitrates fairly between the two streams and buffers dequeued words in a 2-entry output skid buffer, so downstream stalls never lose read data.
- Sits between producer/consumer logic and the storage FIFO instance.

---
 rtl/fifo_1rw_large_host_if.sv | 13 +
 rtl/fifo_1rw_large_host.sv | 110 +++++++++++
 tb/tb_fifo_1rw_large_host.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_1rw_large_host_if.sv
// Command/status bus between the large-FIFO host and the single-port storage FIFO.
// master = host side (issues commands), slave = storage side.
interface fifo_1rw_large_host_if #(parameter int width_p = 8);
    logic               v;
    logic               enq_not_deq;
    logic [width_p-1:0] data;
    logic               full;
    logic               empty;
    logic [width_p-1:0] rdata;

    modport master (output v, enq_not_deq, data, input full, empty, rdata);
    modport slave  (input v, enq_not_deq, data, output full, empty, rdata);
endinterface

// File: rtl/fifo_1rw_large_host.sv
// Host for a single-port large FIFO: merges an enqueue stream and a dequeue stream
// into one command per cycle with fair arbitration and a 2-entry read skid buffer.
module fifo_1rw_large_host_core #(
    parameter int width_p = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width_p-1:0]       enq_data,
    input  logic                     enq_v,
    output logic                     enq_ready,
    output logic                     deq_v,
    output logic [width_p-1:0]       deq_data,
    input  logic                     deq_yumi,
    fifo_1rw_large_host_if.master    fifo
);
    typedef enum logic {GRANT_DEQ, GRANT_ENQ} grant_e;

    logic [width_p-1:0] buf_mem [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               inflight;
    grant_e             last_grant;

    logic [1:0] credit;
    logic       deq_elig;
    logic       enq_elig;
    logic       enq_go;
    logic       deq_go;
    logic       pop;

    // Reset is folded in combinationally so no command or ready leaks out while it is held.
    always_comb begin
        credit    = count + {1'b0, inflight};
        deq_elig  = !rst && !fifo.empty && (credit < 2'd2);
        enq_elig  = !rst && !fifo.full;
        enq_ready = enq_elig && !(deq_elig && (last_grant == GRANT_ENQ));
        enq_go    = enq_v && enq_ready;
        deq_go    = deq_elig && !enq_go;
        pop       = deq_yumi && (count != 2'd0);
        wr_ptr    = rd_ptr ^ count[0];
    end

    assign fifo.v           = enq_go || deq_go;
    assign fifo.enq_not_deq = enq_go;
    assign fifo.data        = enq_data;
    assign deq_v            = (count != 2'd0);
    assign deq_data         = buf_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= 1'b0;
            inflight   <= 1'b0;
            last_grant <= GRANT_DEQ;
        end else begin
            inflight <= deq_go;
            if (fifo.v)
                last_grant <= enq_go ? GRANT_ENQ : GRANT_DEQ;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inflight)
            buf_mem[wr_ptr] <= fifo.rdata;
    end
endmodule

module fifo_1rw_large_host #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               fifo_v_o,
    output logic               fifo_enq_not_deq_o,
    output logic [width_p-1:0] fifo_data_o,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    input  logic [width_p-1:0] fifo_data_i
);
    fifo_1rw_large_host_if #(.width_p(width_p)) fifo_bus ();

    assign fifo_v_o           = fifo_bus.v;
    assign fifo_enq_not_deq_o = fifo_bus.enq_not_deq;
    assign fifo_data_o        = fifo_bus.data;
    assign fifo_bus.full      = fifo_full_i;
    assign fifo_bus.empty     = fifo_empty_i;
    assign fifo_bus.rdata     = fifo_data_i;

    fifo_1rw_large_host_core #(.width_p(width_p)) core (
        .clk       (clk_i),
        .rst       (reset_i),
        .enq_data  (data_i),
        .enq_v     (v_i),
        .enq_ready (ready_o),
        .deq_v     (v_o),
        .deq_data  (data_o),
        .deq_yumi  (yumi_i),
        .fifo      (fifo_bus.master)
    );
endmodule

// File: tb/tb_fifo_1rw_large_host.sv
// Randomised bench for fifo_1rw_large_host: the bench plays the storage FIFO and keeps a
// queue-level model of host buffering, arbitration and end-to-end word order.
module tb_fifo_1rw_large_host;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_i;
    logic         v_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;

    fifo_1rw_large_host_if #(.width_p(W)) store_bus ();

    fifo_1rw_large_host #(.width_p(W)) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .data_i             (data_i),
        .v_i                (v_i),
        .ready_o            (ready_o),
        .v_o                (v_o),
        .data_o             (data_o),
        .yumi_i             (yumi_i),
        .fifo_v_o           (store_bus.v),
        .fifo_enq_not_deq_o (store_bus.enq_not_deq),
        .fifo_data_o        (store_bus.data),
        .fifo_full_i        (store_bus.full),
        .fifo_empty_i       (store_bus.empty),
        .fifo_data_i        (store_bus.rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Storage contents, words held by the host (arrived), and words owed to the consumer in order.
    logic [W-1:0] store_q [$];
    logic [W-1:0] outq    [$];
    logic [W-1:0] sent_q  [$];
    int           depth;
    bit           pend_v;
    logic [W-1:0] pend_word;
    bit           last_enq;

    int obs_enq, obs_deq, obs_pop, cyc, first_cmd, first_vo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        obs_enq = 0; obs_deq = 0; obs_pop = 0; cyc = 0; first_cmd = -1; first_vo = -1;
    endtask

    task automatic preload(input logic [W-1:0] w);
        store_q.push_back(w);
        sent_q.push_back(w);
    endtask

    task automatic step(input bit want_v, input logic [W-1:0] word, input bit want_yumi,
                        output bit accepted);
        bit deq_elig, enq_elig, exp_ready, enq_go, deq_go, yumi;
        @(negedge clk);
        v_i             = want_v;
        data_i          = word;
        yumi            = want_yumi && v_o;
        yumi_i          = yumi;
        store_bus.full  = (store_q.size() >= depth);
        store_bus.empty = (store_q.size() == 0);
        store_bus.rdata = pend_v ? pend_word : W'($urandom);
        #1;
        deq_elig  = (store_q.size() != 0) && ((outq.size() + int'(pend_v)) < 2);
        enq_elig  = (store_q.size() < depth);
        exp_ready = enq_elig && !(deq_elig && last_enq);
        enq_go    = want_v && exp_ready;
        deq_go    = deq_elig && !enq_go;
        check("ready_o", ready_o, exp_ready);
        check("fifo_v_o", store_bus.v, enq_go || deq_go);
        if (enq_go || deq_go) check("fifo_enq_not_deq_o", store_bus.enq_not_deq, enq_go);
        if (enq_go) check("fifo_data_o", store_bus.data, word);
        check("v_o", v_o, outq.size() != 0);
        if (outq.size() != 0) check("data_o", data_o, outq[0]);
        if (store_bus.v === 1'b1) begin
            if (store_bus.enq_not_deq) obs_enq++; else obs_deq++;
            if (first_cmd < 0) first_cmd = cyc;
        end
        if (v_o === 1'b1 && first_vo < 0) first_vo = cyc;
        if (yumi) begin
            check("yumi_while_empty", outq.size() != 0, 1);
            check("pop_order", data_o, (sent_q.size() != 0) ? sent_q.pop_front() : 'x);
            obs_pop++;
            if (outq.size() != 0) void'(outq.pop_front());
        end
        if (pend_v) outq.push_back(pend_word);
        pend_v = deq_go;
        if (deq_go) pend_word = store_q.pop_front();
        if (enq_go) begin
            store_q.push_back(word);
            sent_q.push_back(word);
        end
        if (enq_go || deq_go) last_enq = enq_go;
        accepted = enq_go;
        cyc++;
    endtask

    // Asserts reset mid-cycle with storage looking non-empty so a leaking command would show.
    task automatic do_reset();
        @(negedge clk);
        v_i = 1'b1; yumi_i = 1'b0; data_i = '0;
        store_bus.full = 1'b0; store_bus.empty = 1'b0; store_bus.rdata = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_v_o", v_o, 0);
        check("rst_fifo_v_o", store_bus.v, 0);
        check("rst_ready_o", ready_o, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_v_o", v_o, 0);
        check("rst_hold_fifo_v_o", store_bus.v, 0);
        #1 rst = 1'b0;
        outq.delete();
        pend_v   = 1'b0;
        last_enq = 1'b0;
        sent_q   = store_q;
    endtask

    initial begin
        bit acc;
        int idx;
        logic [W-1:0] w2 [5];
        w2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rst = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        store_bus.full = 1'b0; store_bus.empty = 1'b1; store_bus.rdata = '0;
        depth = 4;
        clear_counts();
        do_reset();

        // 1: reset with one word buffered and one read in flight
        preload(8'h01); preload(8'h02); preload(8'h03);
        step(0, '0, 0, acc);
        step(0, '0, 0, acc);
        do_reset();
        clear_counts();
        repeat (8) step(0, '0, 1, acc);
        check("t1_pops", obs_pop, 1);
        check("t1_v_o_idle", v_o, 0);

        // 2: enqueue only, consumer idle, depth 4
        store_q.delete(); do_reset(); clear_counts();
        idx = 0;
        repeat (40) begin
            step(idx < 5, w2[idx % 5], 0, acc);
            if (acc) idx++;
        end
        check("t2_enq_count", obs_enq, 5);
        check("t2_deq_count", obs_deq, 2);

        // 3: full drain
        store_q.delete(); do_reset(); clear_counts();
        for (int i = 0; i < 4; i++) preload(W'(8'hA0 + i));
        sent_q = store_q;
        repeat (20) step(0, '0, 1, acc);
        check("t3_latency", first_vo - first_cmd, 2);
        check("t3_pops", obs_pop, 4);
        check("t3_v_o_end", v_o, 0);

        // 4: backpressure
        store_q.delete(); do_reset(); clear_counts();
        depth = 8;
        for (int i = 0; i < 5; i++) preload(W'(8'hB0 + i));
        sent_q = store_q;
        repeat (10) step(0, '0, 0, acc);
        check("t4_deq_count", obs_deq, 2);
        #1;
        check("t4_v_o", v_o, 1);
        check("t4_head", data_o, 8'hB0);
        repeat (20) step(0, '0, 1, acc);
        check("t4_pops", obs_pop, 5);

        // 5: contention
        store_q.delete(); do_reset(); clear_counts();
        for (int i = 0; i < 3; i++) preload(W'(8'hC0 + i));
        sent_q = store_q;
        repeat (30) step(1, W'($urandom), 1, acc);
        check("t5_enq_progress", obs_enq != 0, 1);
        check("t5_deq_progress", obs_deq != 0, 1);

        // 6: random soak
        store_q.delete(); do_reset(); clear_counts();
        depth = 4;
        repeat (10000) step($urandom_range(1, 0) == 1, W'($urandom), $urandom_range(2, 0) != 0, acc);
        repeat (50) step(0, '0, 1, acc);
        check("t6_delivered", obs_pop, obs_enq);
        check("t6_residual", sent_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
